// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the time-set controller and the hour/minute/second counters.
// master = controller side, slave = counter/display side.
interface clock_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic       cur_pm;
    logic       sec_cin;
    logic [7:0] data_out;
    logic       load_hour;
    logic       load_min;
    logic       load_sec;
    logic       load_pm;
    logic       pm_out;
    logic       blank_hour;
    logic       blank_min;
    logic       blank_pm;
    logic       setting;

    modport master (
        input  tick_1hz, btn_mode, btn_inc, cur_hour, cur_min, cur_pm,
        output sec_cin, data_out, load_hour, load_min, load_sec, load_pm, pm_out,
        output blank_hour, blank_min, blank_pm, setting
    );

    modport slave (
        output tick_1hz, btn_mode, btn_inc, cur_hour, cur_min, cur_pm,
        input  sec_cin, data_out, load_hour, load_min, load_sec, load_pm, pm_out,
        input  blank_hour, blank_min, blank_pm, setting
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller: edits shadow hour/minute/AM-PM values with two buttons
// and commits them to the counters through a one-hot load sequence.
module clock_set_ctrl (
    input  logic              clk,
    input  logic              reset,
    clock_set_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_PM,
        COMMIT_H,
        COMMIT_M,
        COMMIT_S
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_sh_hour, w_sh_hour_nx;
    logic [7:0] r_sh_min,  w_sh_min_nx;
    logic       r_sh_pm,   w_sh_pm_nx;
    logic [4:0] r_idle,    w_idle_nx;
    logic       r_blink,   w_blink_nx;
    logic       w_in_set;

    function automatic logic [7:0] f_hour_inc(input logic [7:0] h);
        logic [7:0] v;
        v = 8'h01;
        if (h >= 8'h01 && h <= 8'h08)
            v = h + 8'h01;
        else if (h == 8'h09)
            v = 8'h10;
        else if (h == 8'h10 || h == 8'h11)
            v = h + 8'h01;
        return v;
    endfunction

    function automatic logic [7:0] f_min_inc(input logic [7:0] m);
        logic [7:0] v;
        v = '0;
        if (m[7:4] <= 4'd5 && m[3:0] <= 4'd9 && m != 8'h59) begin
            if (m[3:0] == 4'd9)
                v = {m[7:4] + 4'd1, 4'h0};
            else
                v = {m[7:4], m[3:0] + 4'd1};
        end
        return v;
    endfunction

    assign w_in_set = (r_state == SET_HOUR) || (r_state == SET_MIN) || (r_state == SET_PM);

    always_comb begin
        w_next       = r_state;
        w_sh_hour_nx = r_sh_hour;
        w_sh_min_nx  = r_sh_min;
        w_sh_pm_nx   = r_sh_pm;
        w_idle_nx    = r_idle;
        w_blink_nx   = r_blink;
        case (r_state)
            RUN: begin
                w_idle_nx  = '0;
                w_blink_nx = 1'b0;
                if (bus.btn_mode) begin
                    w_next       = SET_HOUR;
                    w_sh_hour_nx = bus.cur_hour;
                    w_sh_min_nx  = bus.cur_min;
                    w_sh_pm_nx   = bus.cur_pm;
                end
            end
            SET_HOUR, SET_MIN, SET_PM: begin
                if (bus.btn_mode) begin
                    w_idle_nx = '0;
                    case (r_state)
                        SET_HOUR: w_next = SET_MIN;
                        SET_MIN:  w_next = SET_PM;
                        default:  w_next = COMMIT_H;
                    endcase
                end else if (bus.btn_inc) begin
                    w_idle_nx = '0;
                    if (r_state == SET_HOUR)
                        w_sh_hour_nx = f_hour_inc(r_sh_hour);
                    else if (r_state == SET_MIN)
                        w_sh_min_nx = f_min_inc(r_sh_min);
                    else
                        w_sh_pm_nx = ~r_sh_pm;
                end else if (bus.tick_1hz) begin
                    // The 30th idle tick aborts directly rather than parking a count of 30.
                    if (r_idle == 5'd29)
                        w_next = RUN;
                    else
                        w_idle_nx = r_idle + 5'd1;
                end
                if (bus.tick_1hz)
                    w_blink_nx = ~r_blink;
                if (w_next == RUN) begin
                    w_idle_nx  = '0;
                    w_blink_nx = 1'b0;
                end
            end
            COMMIT_H: w_next = COMMIT_M;
            COMMIT_M: w_next = COMMIT_S;
            COMMIT_S: begin
                w_next     = RUN;
                w_blink_nx = 1'b0;
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_sh_hour <= 8'h12;
            r_sh_min  <= 8'h00;
            r_sh_pm   <= 1'b0;
            r_idle    <= '0;
            r_blink   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sh_hour <= w_sh_hour_nx;
            r_sh_min  <= w_sh_min_nx;
            r_sh_pm   <= w_sh_pm_nx;
            r_idle    <= w_idle_nx;
            r_blink   <= w_blink_nx;
        end
    end

    assign bus.sec_cin = (r_state == RUN) && bus.tick_1hz;

    // Reset gates the decoded outputs so an interrupted commit stops loading at once.
    always_comb begin
        bus.data_out   = '0;
        bus.load_hour  = 1'b0;
        bus.load_min   = 1'b0;
        bus.load_sec   = 1'b0;
        bus.load_pm    = 1'b0;
        bus.pm_out     = 1'b0;
        bus.blank_hour = 1'b0;
        bus.blank_min  = 1'b0;
        bus.blank_pm   = 1'b0;
        bus.setting    = 1'b0;
        if (!reset) begin
            bus.setting = (r_state != RUN);
            case (r_state)
                SET_HOUR: bus.blank_hour = r_blink;
                SET_MIN:  bus.blank_min  = r_blink;
                SET_PM:   bus.blank_pm   = r_blink;
                COMMIT_H: begin
                    bus.load_hour = 1'b1;
                    bus.load_pm   = 1'b1;
                    bus.pm_out    = r_sh_pm;
                    bus.data_out  = r_sh_hour;
                end
                COMMIT_M: begin
                    bus.load_min = 1'b1;
                    bus.data_out = r_sh_min;
                end
                COMMIT_S: bus.load_sec = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_clock_set_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n_sec = 0;
    int   n_load_any = 0;
    int   n_load_sec = 0;

    clock_set_ctrl_if bus ();

    clock_set_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edit mode 0 = running, 1..3 = editing hour/min/pm, 4..6 = commit cycles.
    int         m_mode  = 0;
    logic [7:0] m_hour  = 8'h12;
    logic [7:0] m_min   = 8'h00;
    logic       m_pm    = 1'b0;
    int         m_idle  = 0;
    logic       m_blink = 1'b0;

    function automatic logic [7:0] hour_after_inc(input logic [7:0] h);
        int v;
        int nv;
        v  = int'(h[7:4]) * 10 + int'(h[3:0]);
        nv = (h[3:0] <= 4'd9 && v >= 1 && v < 12) ? v + 1 : 1;
        return 8'((nv / 10) * 16 + (nv % 10));
    endfunction

    function automatic logic [7:0] min_after_inc(input logic [7:0] m);
        int v;
        int nv;
        v  = int'(m[7:4]) * 10 + int'(m[3:0]);
        nv = (m[3:0] <= 4'd9 && m[7:4] <= 4'd5 && v < 59) ? v + 1 : 0;
        return 8'((nv / 10) * 16 + (nv % 10));
    endfunction

    initial begin
        logic [17:0] exp_v;
        logic [17:0] act_v;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_v = '0;
            exp_v[17] = (m_mode == 0) && bus.tick_1hz;
            if (!rst) begin
                exp_v[16] = (m_mode != 0);
                exp_v[15] = (m_mode == 4);
                exp_v[14] = (m_mode == 5);
                exp_v[13] = (m_mode == 6);
                exp_v[12] = (m_mode == 4);
                exp_v[11] = (m_mode == 4) && m_pm;
                exp_v[10] = (m_mode == 1) && m_blink;
                exp_v[9]  = (m_mode == 2) && m_blink;
                exp_v[8]  = (m_mode == 3) && m_blink;
                exp_v[7:0] = (m_mode == 4) ? m_hour : (m_mode == 5) ? m_min : 8'h00;
            end
            act_v = {bus.sec_cin, bus.setting, bus.load_hour, bus.load_min, bus.load_sec,
                     bus.load_pm, bus.pm_out, bus.blank_hour, bus.blank_min, bus.blank_pm,
                     bus.data_out};
            chk("outputs_vs_model", 32'(act_v), 32'(exp_v));

            if (rst) begin
                m_mode = 0; m_hour = 8'h12; m_min = 8'h00; m_pm = 1'b0;
                m_idle = 0; m_blink = 1'b0;
            end else if (m_mode == 0) begin
                if (bus.btn_mode) begin
                    m_mode = 1; m_hour = bus.cur_hour; m_min = bus.cur_min; m_pm = bus.cur_pm;
                    m_idle = 0; m_blink = 1'b0;
                end
            end else if (m_mode <= 3) begin
                if (bus.tick_1hz) m_blink = ~m_blink;
                if (bus.btn_mode) begin
                    m_mode = m_mode + 1;
                    m_idle = 0;
                end else if (bus.btn_inc) begin
                    m_idle = 0;
                    if (m_mode == 1) m_hour = hour_after_inc(m_hour);
                    else if (m_mode == 2) m_min = min_after_inc(m_min);
                    else m_pm = ~m_pm;
                end else if (bus.tick_1hz) begin
                    m_idle = m_idle + 1;
                    if (m_idle == 30) begin
                        m_mode = 0; m_idle = 0; m_blink = 1'b0;
                    end
                end
            end else begin
                m_mode = (m_mode == 6) ? 0 : m_mode + 1;
                if (m_mode == 0) m_blink = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.sec_cin) n_sec <= n_sec + 1;
        if (bus.load_hour || bus.load_min || bus.load_sec || bus.load_pm)
            n_load_any <= n_load_any + 1;
        if (bus.load_sec) n_load_sec <= n_load_sec + 1;
    end

    task automatic step(input logic t, input logic m, input logic i);
        bus.tick_1hz = t; bus.btn_mode = m; bus.btn_inc = i;
        @(posedge clk); #1;
        bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic pm);
        bus.cur_hour = h; bus.cur_min = m; bus.cur_pm = pm;
    endtask

    // Checks the three commit cycles (entered on the preceding edge) and the return to running.
    task automatic chk_commit(input string name, input logic [7:0] eh, input logic [7:0] em,
                              input logic ep);
        chk({name, "_commit_h"}, 32'({bus.load_hour, bus.load_min, bus.load_sec, bus.load_pm,
            bus.pm_out, bus.data_out}), 32'({4'b1001, ep, eh}));
        step(0, 0, 0);
        chk({name, "_commit_m"}, 32'({bus.load_hour, bus.load_min, bus.load_sec, bus.load_pm,
            bus.data_out}), 32'({4'b0100, em}));
        step(0, 0, 0);
        chk({name, "_commit_s"}, 32'({bus.load_hour, bus.load_min, bus.load_sec, bus.load_pm,
            bus.data_out}), 32'({4'b0010, 8'h00}));
        step(0, 0, 0);
        chk({name, "_back_to_run"}, 32'({bus.setting, bus.load_hour, bus.load_min, bus.load_sec}),
            32'(0));
    endtask

    task automatic edit(input string name, input logic [7:0] h, input logic [7:0] m,
                        input logic pm, input int nh, input int nm, input int np,
                        input logic [7:0] eh, input logic [7:0] em, input logic ep);
        set_cur(h, m, pm);
        step(0, 1, 0);
        for (int k = 0; k < nh; k++) step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 0; k < nm; k++) step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 0; k < np; k++) step(0, 0, 1);
        step(0, 1, 0);
        chk_commit(name, eh, em, ep);
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        set_cur(8'h10, 8'h10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus.setting, bus.load_hour, bus.load_min, bus.load_sec,
            bus.load_pm, bus.blank_hour, bus.blank_min, bus.blank_pm, bus.data_out}), 32'(0));
        rst = 1'b0;
        step(0, 0, 0);

        n0 = n_sec;
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        chk("run_sec_cin_count", 32'(n_sec - n0), 32'd3);

        edit("full_edit", 8'h11, 8'h58, 1'b0, 1, 2, 1, 8'h12, 8'h00, 1'b1);
        edit("hour_09", 8'h09, 8'h30, 1'b1, 1, 0, 0, 8'h10, 8'h30, 1'b1);
        edit("hour_12", 8'h12, 8'h07, 1'b0, 1, 0, 0, 8'h01, 8'h07, 1'b0);
        edit("min_59", 8'h03, 8'h59, 1'b0, 0, 1, 0, 8'h03, 8'h00, 1'b0);
        edit("illegal", 8'h1A, 8'h7F, 1'b1, 1, 1, 2, 8'h01, 8'h00, 1'b1);

        set_cur(8'h05, 8'h20, 1'b0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        chk_commit("mode_beats_inc", 8'h05, 8'h20, 1'b0);

        set_cur(8'h07, 8'h15, 1'b1);
        step(0, 1, 0);
        n0 = n_load_any;
        for (int k = 0; k < 29; k++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        chk("idle29_still_setting", 32'({bus.setting, bus.blank_hour}), 32'(2'b11));
        step(1, 0, 0);
        chk("idle30_abort", 32'({bus.setting, bus.blank_hour}), 32'(0));
        chk("abort_no_loads", 32'(n_load_any - n0), 32'(0));
        bus.tick_1hz = 1'b1;
        @(negedge clk);
        chk("sec_cin_after_abort", 32'(bus.sec_cin), 32'(1));
        @(posedge clk); #1;
        bus.tick_1hz = 1'b0;

        set_cur(8'h02, 8'h33, 1'b0);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        n0 = n_load_sec;
        step(0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_commit_min", 32'(bus.load_min), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("reset_commit_no_sec_load", 32'(n_load_sec - n0), 32'(0));
        chk("reset_commit_run", 32'(bus.setting), 32'(0));

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    bus.cur_hour = 8'($urandom_range(0, 255));
                else
                    bus.cur_hour = 8'($urandom_range(1, 12) / 10 * 16 + $urandom_range(1, 12) % 10);
                bus.cur_min = 8'($urandom_range(0, 255));
                bus.cur_pm  = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 299) == 0);
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 8) == 0),
                 1'($urandom_range(0, 2) == 0));
            rst = 1'b0;
        end
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the system clock (all logic on its rising edge).
REQ-002 The block SHALL have the port reset, input, 1 bit, a synchronous, active-high reset.
REQ-003 The block SHALL have the port tick_1hz, input, 1 bit, a one-cycle pulse once per second.
REQ-004 The block SHALL have the ports btn_mode and btn_inc, inputs, 1 bit each, already-debounced single-cycle pulses.
REQ-005 The block SHALL have the ports cur_hour and cur_min, inputs, 8 bits each, the live BCD time from the hour/minute counters.
REQ-006 The block SHALL have the port cur_pm, input, 1 bit, the live AM/PM flag (1 = PM).
REQ-007 The block SHALL have the port sec_cin, output, 1 bit, the count enable into the seconds counter.
REQ-008 The block SHALL have the port data_out, output, 8 bits, the shared BCD load bus to the counters.
REQ-009 The block SHALL have the ports load_hour, load_min and load_sec, outputs, 1 bit each, one-hot load strobes.
REQ-010 The block SHALL have the ports load_pm, output, 1 bit, and pm_out, output, 1 bit, the AM/PM load strobe and its value.
REQ-011 The block SHALL have the ports blank_hour, blank_min and blank_pm, outputs, 1 bit each, display blanking for blinking the field being edited.
REQ-012 The block SHALL have the port setting, output, 1 bit, high in any state other than RUN.

Function
REQ-013 The FSM SHALL have the states RUN, SET_HOUR, SET_MIN, SET_PM, COMMIT_H, COMMIT_M, COMMIT_S.
REQ-014 In RUN, sec_cin SHALL equal tick_1hz (combinational); in every other state sec_cin SHALL be 0, and ticks are dropped, not queued.
REQ-015 In RUN, btn_mode SHALL capture cur_hour, cur_min and cur_pm into shadow registers sh_hour, sh_min and sh_pm and move the FSM to SET_HOUR on the next edge.
REQ-016 In the SET states, btn_mode SHALL advance the FSM SET_HOUR->SET_MIN->SET_PM->COMMIT_H.
REQ-017 btn_inc in SET_HOUR SHALL step sh_hour BCD 01..09,10,11,12,01; a value of 12 or any non-legal value SHALL go to 01.
REQ-018 btn_inc in SET_MIN SHALL step sh_min BCD 00..59 with the low digit carrying at 9; a value of 59 or any non-legal value SHALL go to 00.
REQ-019 btn_inc in SET_PM SHALL toggle sh_pm.
REQ-020 btn_inc in RUN or in any COMMIT state SHALL be ignored.
REQ-021 When btn_mode and btn_inc arrive in the same cycle, mode SHALL win and inc SHALL be discarded.
REQ-022 COMMIT_H SHALL last one cycle with load_hour=1, data_out=sh_hour, load_pm=1 and pm_out=sh_pm.
REQ-023 COMMIT_M SHALL last one cycle with load_min=1 and data_out=sh_min.
REQ-024 COMMIT_S SHALL last one cycle with load_sec=1 and data_out=8'h00, then the FSM SHALL return to RUN.
REQ-025 The load strobes SHALL never overlap, and buttons SHALL be ignored during the COMMIT states.
REQ-026 Outside the COMMIT states, all load strobes SHALL be 0 and data_out SHALL be 8'h00.
REQ-027 A 5-bit idle timer SHALL clear on any button pulse and on entry to SET_HOUR, and SHALL increment on tick_1hz in the SET states.
REQ-028 When the idle timer reaches 30, the FSM SHALL abort to RUN with no loads issued, and the shadow values SHALL be discarded.
REQ-029 A blink_phase bit SHALL toggle on tick_1hz in the SET states and SHALL be cleared on entry to SET_HOUR and on return to RUN.
REQ-030 blank_hour SHALL equal (state==SET_HOUR)&blink_phase, with the same rule for blank_min (SET_MIN) and blank_pm (SET_PM).
REQ-031 All outputs other than sec_cin SHALL be registered or decoded from state only, with no combinational path from a button input.

Reset
REQ-032 Reset SHALL place the FSM in RUN and set sh_hour=8'h12, sh_min=8'h00, sh_pm=0, idle timer 0 and blink_phase 0.
REQ-033 During reset all load strobes, all blank outputs and setting SHALL be 0, and data_out SHALL be 8'h00.
REQ-034 Reset SHALL take priority in every state; a reset asserted mid-commit SHALL suppress the remaining loads and return to RUN.

Verification
REQ-035 The bench SHALL cover: RUN with 3 ticks -> sec_cin pulses exactly 3 times, coincident with the ticks.
REQ-036 The bench SHALL cover: cur=11:58 AM, mode, inc, mode, inc x2, mode, inc, mode -> COMMIT_H loads 8'h12 with pm_out=1, COMMIT_M loads 8'h00, COMMIT_S loads 8'h00, each on consecutive single cycles, then RUN.
REQ-037 The bench SHALL cover: SET_MIN from 8'h59 with inc -> 8'h00; SET_HOUR from 8'h09 with inc -> 8'h10, and from 8'h12 with inc -> 8'h01.
REQ-038 The bench SHALL cover: SET_HOUR with 30 ticks and no buttons -> return to RUN, no load strobe asserted, and sec_cin resumes on the next tick.
REQ-039 The bench SHALL cover: mode and inc in the same cycle in SET_HOUR -> FSM goes to SET_MIN and sh_hour is unchanged.
REQ-040 The bench SHALL cover: reset asserted during COMMIT_M -> load_sec is never asserted and the FSM is in RUN with setting=0.
